wb_arbiter: RTL and testbench

Writeback arbiter sitting directly upstream of the 32x32 register file write port. Merges single-cycle ALU results and handshaked long-latency results (loads, multiply/divide) into the file's single write port. Long results are buffered in a small FIFO. A per-register busy scoreboard lets the issue stage stall on outstanding long-latency destinations. Writes to register 0 are discarded, which keeps x0 at zero even though the register file does not protect it.

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered long-latency results into the single
// register-file write port, and tracks outstanding long destinations in a busy scoreboard.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        lng_valid,
  output logic        lng_ready,
  input  logic [4:0]  lng_reg,
  input  logic [31:0] lng_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [31:0] busy,
  output logic        stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

  logic [36:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          alu_wr_s;
  logic          push_s;
  logic          pop_s;
  logic [36:0]   head_s;
  logic [31:0]   set_mask_s;
  logic [31:0]   clr_mask_s;
  logic          reg_write_r;
  logic [4:0]    write_reg_r;
  logic [31:0]   write_data_r;
  logic [31:0]   busy_r;
  logic          stall_req_r;

  assign lng_ready  = (count_r != FULL_CNT);
  assign reg_write  = reg_write_r;
  assign write_reg  = write_reg_r;
  assign write_data = write_data_r;
  assign busy       = busy_r;
  assign stall_req  = stall_req_r;

  // Arbitration decision, FIFO count update and scoreboard masks.
  always_comb begin
    alu_wr_s    = alu_valid && (alu_reg != 5'd0);
    push_s      = lng_valid && lng_ready && (lng_reg != 5'd0);
    pop_s       = !alu_wr_s && (count_r != {CW{1'b0}});
    head_s      = mem_r[rd_ptr_r];
    count_nxt_s = count_r;
    set_mask_s  = 32'd0;
    clr_mask_s  = 32'd0;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      clr_mask_s = 32'd1 << head_s[36:32];
    end else begin
      clr_mask_s = 32'd0;
    end
    if (issue_valid) begin
      set_mask_s = 32'd1 << issue_reg;
    end else begin
      set_mask_s = 32'd0;
    end
  end

  // FIFO storage needs no reset: entries are only read below the count.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {lng_reg, lng_data};
    end
  end

  // FIFO pointers/count, write-port stage and scoreboard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      reg_write_r  <= 1'b0;
      write_reg_r  <= 5'd0;
      write_data_r <= 32'd0;
      busy_r       <= 32'd0;
      stall_req_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_nxt_s;
      stall_req_r <= (count_nxt_s >= STALL_CNT);
      if (alu_wr_s) begin
        reg_write_r  <= 1'b1;
        write_reg_r  <= alu_reg;
        write_data_r <= alu_data;
      end else if (pop_s) begin
        reg_write_r  <= 1'b1;
        write_reg_r  <= head_s[36:32];
        write_data_r <= head_s[31:0];
      end else begin
        reg_write_r  <= 1'b0;
      end
      // Set is applied after clear so a same-cycle issue keeps the register busy.
      busy_r <= ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference model predicts each edge's outputs,
// which are queued at drive time and compared after the edge.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        lng_valid;
  logic        lng_ready;
  logic [4:0]  lng_reg;
  logic [31:0] lng_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy;
  logic        stall_req;

  typedef struct {
    logic        wr;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] bsy;
    logic        stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [36:0] mq[$];
  logic [31:0] m_busy;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          total_cnt = 0;
  int          bad_cnt   = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_reg(lng_reg), .lng_data(lng_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .busy(busy), .stall_req(stall_req)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ir);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    lng_valid = lv; lng_reg = lr; lng_data = ld;
    issue_valid = iv; issue_reg = ir;
  endtask

  // One clock: predict the edge, queue the prediction, then compare after the edge.
  task automatic step();
    exp_t        e;
    logic        rdy;
    logic        aw;
    logic        pop;
    logic        push;
    logic [36:0] h;
    rdy  = (mq.size() != DEPTH);
    check("lng_ready", 64'(lng_ready), 64'(rdy));
    aw   = alu_valid && (alu_reg != 5'd0);
    pop  = !aw && (mq.size() != 0);
    push = lng_valid && rdy && (lng_reg != 5'd0);
    if (aw) begin
      m_reg = alu_reg; m_data = alu_data;
    end else if (pop) begin
      h = mq.pop_front();
      m_reg = h[36:32]; m_data = h[31:0];
      m_busy[h[36:32]] = 1'b0;
    end
    if (issue_valid) m_busy[issue_reg] = 1'b1;
    m_busy[0] = 1'b0;
    if (push) mq.push_back({lng_reg, lng_data});
    e.wr = aw || pop; e.r = m_reg; e.d = m_data; e.bsy = m_busy;
    e.stall = (mq.size() >= DEPTH - 1);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("reg_write",  64'(reg_write),  64'(e.wr));
    check("write_reg",  64'(write_reg),  64'(e.r));
    check("write_data", 64'(write_data), 64'(e.d));
    check("busy",       64'(busy),       64'(e.bsy));
    check("stall_req",  64'(stall_req),  64'(e.stall));
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset mid-cycle and check the asynchronous reset state.
  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    check("rst_reg_write",  64'(reg_write),  64'd0);
    check("rst_write_reg",  64'(write_reg),  64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_stall_req",  64'(stall_req),  64'd0);
    check("rst_lng_ready",  64'(lng_ready),  64'd1);
    mq.delete(); exp_q.delete();
    m_busy = 32'd0; m_reg = 5'd0; m_data = 32'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] r;
    reset = 1'b0;
    do_reset();
    idle(2);

    // ALU path, then a dropped ALU write to x0.
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    check("alu_wr",   64'(reg_write),  64'd1);
    check("alu_reg",  64'(write_reg),  64'd5);
    check("alu_data", 64'(write_data), 64'hDEADBEEF);
    set_in(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    check("alu_x0_dropped", 64'(reg_write), 64'd0);

    // Long path with scoreboard on reg 9.
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step();
    check("busy9_set", 64'(busy[9]), 64'd1);
    idle(2);
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0);
    step();
    check("busy9_held", 64'(busy[9]), 64'd1);
    idle(1);
    check("lng9_write", 64'({reg_write, write_reg, write_data}), {27'd0, 1'b1, 5'd9, 32'h1234});
    check("busy9_clr",  64'(busy[9]), 64'd0);

    // Priority and fill: ALU every cycle blocks pops while long results pile up.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 5'(20 + i), 32'hC000 + 32'(i), 1'b1, 5'(10 + i), 32'hA000 + 32'(i), 1'b0, 5'd0);
      step();
    end
    check("fill_not_ready", 64'(lng_ready), 64'd0);
    check("fill_stall",     64'(stall_req), 64'd1);
    idle(1);
    check("ready_after_pop", 64'(lng_ready), 64'd1);
    idle(4);

    // Push and pop together at count 2, then issue to reg 7 while popping a reg-7 result.
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd0);
    step();
    set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0);
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0);
    step();
    check("count2_no_stall", 64'(stall_req), 64'd0);
    idle(1);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    step();
    check("pop7_write",      64'(write_reg), 64'd7);
    check("busy7_set_wins",  64'(busy[7]),   64'd1);

    // Long result to x0 is consumed but never written.
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555, 1'b0, 5'd0);
    step();
    idle(1);
    check("lng_x0_no_write", 64'(reg_write), 64'd0);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd1, 32'(i), 1'b1, 5'(16 + i), 32'hB000 + 32'(i), 1'b1, 5'(16 + i));
      step();
    end
    do_reset();
    idle(4);

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      r = 5'($urandom_range(1, 31));
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
             !m_busy[r] && ($urandom_range(0, 3) == 0), r);
      step();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
